hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Combined hazard detection and forwarding controller for the 5-stage MIPS pipeline; sits beside the ID/EX/MEM/WB pipeline registers.
- Successor to the existing forwarding controller: parametrised register-address width and multi-cycle latency, with the following additions:
  - register 0 excluded from every match;
  - gating by source-used flags;
  - load-use stall and bubble generation;
  - a multi-cycle EX operation (mul/div) stall FSM;
  - a saturating stall-cycle counter.

Parameters:
- AW, 5: register address width.
- MC_LATENCY, 4: total EX cycles of a multi-cycle op. Legal range is at least 2.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  AW  source addresses of the instruction in ID.
- id_rs_used, id_rt_used  in  1  the ID instruction actually reads that source.
- id_ex_rs, id_ex_rt  in  AW  source addresses held in ID/EX.
- id_ex_rd  in  AW  destination held in ID/EX.
- id_ex_mem_read  in  1  ID/EX instruction is a load.
- id_ex_mc  in  1  ID/EX instruction is a multi-cycle op.
- ex_mem_rd, mem_wb_rd  in  AW  destinations in EX/MEM and MEM/WB.
- ex_mem_reg_write, mem_wb_reg_write  in  1  write enables for those destinations.
- fwd_a, fwd_b  out  2  EX operand muxes: 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- fwd_id_rs, fwd_id_rt  out  1  in ID, take the WB write data instead of the register file.
- stall_pc, stall_ifid  out  1  hold the PC and the IF/ID register.
- bubble_idex  out  1  load a NOP into ID/EX.
- hold_ex  out  1  freeze ID/EX and the EX unit; insert a bubble into EX/MEM.
- mc_busy  out  1  FSM is in MC_BUSY.
- mc_done  out  1  one-cycle pulse in the final EX cycle of a multi-cycle op.
- stall_count  out  CNT_W  number of front-end stall cycles since reset.

Behaviour:
- Reset: rst is sampled on the clk edge.
  - Sets state RUN, the latency counter to 0, and stall_count to 0.
  - While rst=1, every output is forced to 0, including the combinational ones.
  - Reset during MC_BUSY abandons the op; no mc_done is produced.
- Forwarding (combinational, per EX operand, shown for fwd_a/id_ex_rs):
  - 01 if ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==id_ex_rs;
  - else 10 if mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==id_ex_rs;
  - else 00.
  - EX/MEM has priority when both stages match.
  - fwd_b is identical, using id_ex_rt.
- ID forwarding: fwd_id_rs = mem_wb_reg_write && mem_wb_rd!=0 && mem_wb_rd==id_rs. fwd_id_rt is the same using id_rt.
- FSM states: RUN and MC_BUSY. The 2-bit state encoding lives in the package.
- RUN, with id_ex_mc=1 (multi-cycle op entering EX):
  - assert hold_ex, stall_pc and stall_ifid;
  - load the counter with MC_LATENCY-2;
  - next state MC_BUSY.
- RUN, with id_ex_mc=0 (load-use check):
  - load_use = id_ex_mem_read && id_ex_rd!=0 && ((id_rs_used && id_ex_rd==id_rs) || (id_rt_used && id_ex_rd==id_rt)).
  - load_use asserts stall_pc, stall_ifid and bubble_idex for that cycle only; state stays RUN.
- MC_BUSY, counter != 0: assert hold_ex, stall_pc, stall_ifid and mc_busy; decrement the counter.
- MC_BUSY, counter == 0: assert mc_busy and mc_done; deassert all holds; next state RUN.
- MC_BUSY timing: an op detected in cycle T gets holds in cycles T..T+MC_LATENCY-2 and mc_done in cycle T+MC_LATENCY-1.
- Simultaneous events:
  - The multi-cycle path overrides load-use; bubble_idex is never asserted together with hold_ex.
  - Load-use is not evaluated in MC_BUSY.
  - Forwarding outputs remain live in all states.
- stall_count: increments on every clock with stall_pc=1 and rst=0, and saturates at all-ones with no wrap.

Decomposition:
- Package hazard_pkg holds: the FWD_RF/FWD_EXMEM/FWD_MEMWB 2-bit constants, the RUN/MC_BUSY state constants, and the REG_ZERO constant.
- One sub-module, fwd_select: a single-operand priority comparator (AW parameter). It is instantiated for fwd_a and fwd_b; the ID-stage forwarding uses its MEM/WB compare.
- The FSM, counters and load-use logic stay in the top module.

Test Plan:
- Priority forwarding: ex_mem_rd=mem_wb_rd=id_ex_rs=5, both write enables=1 -> fwd_a=01. Then drop ex_mem_reg_write -> fwd_a=10. Then set id_ex_rs=0 with matching rd=0 -> fwd_a=00.
- Load-use: id_ex_mem_read=1, id_ex_rd=8, id_rt=8, id_rt_used=1 -> stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle, stall_count 0->1. Repeat with id_rt_used=0 -> no stall.
- Multi-cycle, MC_LATENCY=4: id_ex_mc=1 at cycle T -> hold_ex=1 in T, T+1, T+2; mc_done=1 only in T+3; stall_count=3; state returns to RUN in T+4.
- Overlap: id_ex_mc=1 together with a load-use match -> hold_ex=1, bubble_idex=0. During MC_BUSY, present a load-use match -> bubble_idex stays 0.
- Reset mid-op: rst=1 at T+1 of a multi-cycle op -> all outputs 0, no mc_done. After rst falls, state is RUN and stall_count=0.
- Saturation, CNT_W=2: 5 stall cycles -> stall_count holds at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard detection / forwarding controller.
//   FWD_*    : EX operand mux select encodings
//   state_t  : controller FSM states (2-bit encoding)
//   REG_ZERO : hard-wired zero register, never a forwarding/hazard source
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MC_BUSY = 2'b01
    } state_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding priority comparator.
//   src              : source register address being resolved
//   ex_mem_rd/_we    : EX/MEM destination and write enable (higher priority)
//   mem_wb_rd/_we    : MEM/WB destination and write enable
//   fwd              : FWD_EXMEM, FWD_MEMWB or FWD_RF
// Register 0 never matches.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic          ex_mem_reg_write,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic          mem_wb_reg_write,
    output logic [1:0]    fwd
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = ex_mem_reg_write && (ex_mem_rd != AW'(REG_ZERO)) && (ex_mem_rd == src);
    assign mem_wb_hit = mem_wb_reg_write && (mem_wb_rd != AW'(REG_ZERO)) && (mem_wb_rd == src);

    always_comb begin
        fwd = FWD_RF;
        if (ex_mem_hit)
            fwd = FWD_EXMEM;
        else if (mem_wb_hit)
            fwd = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding controller for the 5-stage MIPS pipeline.
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs/id_rt(+_used)      : sources of the instruction in ID
//   id_ex_rs/rt/rd           : operands and destination held in ID/EX
//   id_ex_mem_read, id_ex_mc : ID/EX holds a load / a multi-cycle op
//   ex_mem_*, mem_wb_*       : downstream destinations and write enables
//   fwd_a, fwd_b             : EX operand mux selects
//   fwd_id_rs, fwd_id_rt     : ID-stage bypass of the WB write data
//   stall_pc, stall_ifid     : front-end hold
//   bubble_idex              : load a NOP into ID/EX (load-use)
//   hold_ex                  : freeze ID/EX and EX, bubble into EX/MEM
//   mc_busy, mc_done         : multi-cycle op in progress / final EX cycle
//   stall_count              : saturating count of front-end stall cycles
// All outputs read 0 while rst is high.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned AW         = 5,
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [AW-1:0]    id_ex_rs,
    input  logic [AW-1:0]    id_ex_rt,
    input  logic [AW-1:0]    id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_mc,
    input  logic [AW-1:0]    ex_mem_rd,
    input  logic [AW-1:0]    mem_wb_rd,
    input  logic             ex_mem_reg_write,
    input  logic             mem_wb_reg_write,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             fwd_id_rs,
    output logic             fwd_id_rt,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             hold_ex,
    output logic             mc_busy,
    output logic             mc_done,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned LAT_W = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;

    state_t             state;
    logic [LAT_W-1:0]   lat_cnt;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         sel_a;
    logic [1:0]         sel_b;
    logic [1:0]         sel_id_rs;
    logic [1:0]         sel_id_rt;
    logic               load_use;

    fwd_select #(.AW(AW)) u_fwd_a (
        .src(id_ex_rs), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .fwd(sel_a)
    );

    fwd_select #(.AW(AW)) u_fwd_b (
        .src(id_ex_rt), .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .fwd(sel_b)
    );

    // ID bypass reuses the comparator with the EX/MEM leg disabled, so a
    // FWD_MEMWB result is exactly the MEM/WB match.
    fwd_select #(.AW(AW)) u_fwd_id_rs (
        .src(id_rs), .ex_mem_rd('0), .ex_mem_reg_write(1'b0),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .fwd(sel_id_rs)
    );

    fwd_select #(.AW(AW)) u_fwd_id_rt (
        .src(id_rt), .ex_mem_rd('0), .ex_mem_reg_write(1'b0),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .fwd(sel_id_rt)
    );

    assign fwd_a       = rst ? FWD_RF : sel_a;
    assign fwd_b       = rst ? FWD_RF : sel_b;
    assign fwd_id_rs   = !rst && (sel_id_rs == FWD_MEMWB);
    assign fwd_id_rt   = !rst && (sel_id_rt == FWD_MEMWB);
    assign stall_count = rst ? '0 : cnt_q;

    assign load_use = id_ex_mem_read && (id_ex_rd != AW'(REG_ZERO)) &&
                      ((id_rs_used && (id_ex_rd == id_rs)) ||
                       (id_rt_used && (id_ex_rd == id_rt)));

    // Multi-cycle entry outranks load-use, so bubble_idex and hold_ex are
    // mutually exclusive; load-use is ignored entirely while busy.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        hold_ex     = 1'b0;
        mc_busy     = 1'b0;
        mc_done     = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (id_ex_mc) begin
                        hold_ex    = 1'b1;
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                    end else if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end
                end
                MC_BUSY: begin
                    mc_busy = 1'b1;
                    if (lat_cnt != '0) begin
                        hold_ex    = 1'b1;
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                    end else begin
                        mc_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry cycle counts as the first hold, so the counter starts at
    // MC_LATENCY-2 and mc_done lands in cycle T+MC_LATENCY-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            lat_cnt <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (id_ex_mc) begin
                        lat_cnt <= LAT_W'(MC_LATENCY - 2);
                        state   <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    if (lat_cnt != '0)
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    else
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
            if (stall_pc && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       rs_used;
        logic       rt_used;
        logic [4:0] ex_rs;
        logic [4:0] ex_rt;
        logic [4:0] ex_rd;
        logic       mem_read;
        logic       mc;
        logic [4:0] em_rd;
        logic       em_we;
        logic [4:0] mw_rd;
        logic       mw_we;
    } in_t;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fir;
        logic       fit;
        logic       spc;
        logic       bub;
        logic       hold;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  ex;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_ex_rs, id_ex_rt, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic        id_rs_used, id_rt_used, id_ex_mem_read, id_ex_mc;
    logic        ex_mem_reg_write, mem_wb_reg_write;

    logic [1:0]  fwd_a, fwd_b;
    logic        fwd_id_rs, fwd_id_rt, stall_pc, stall_ifid, bubble_idex;
    logic        hold_ex, mc_busy, mc_done;
    logic [15:0] stall_count;

    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_fwd_id_rs, s_fwd_id_rt, s_stall_pc, s_stall_ifid, s_bubble_idex;
    logic        s_hold_ex, s_mc_busy, s_mc_done;
    logic [1:0]  s_stall_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_forward_unit #(.AW(5), .MC_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mc(id_ex_mc),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_rs(fwd_id_rs), .fwd_id_rt(fwd_id_rt),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .hold_ex(hold_ex), .mc_busy(mc_busy), .mc_done(mc_done),
        .stall_count(stall_count)
    );

    hazard_forward_unit #(.AW(5), .MC_LATENCY(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mc(id_ex_mc),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_reg_write(ex_mem_reg_write), .mem_wb_reg_write(mem_wb_reg_write),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_id_rs(s_fwd_id_rs), .fwd_id_rt(s_fwd_id_rt),
        .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .bubble_idex(s_bubble_idex),
        .hold_ex(s_hold_ex), .mc_busy(s_mc_busy), .mc_done(s_mc_done),
        .stall_count(s_stall_count)
    );

    function automatic in_t mk_in(
        input logic [4:0] a_id_rs, input logic [4:0] a_id_rt,
        input logic a_rs_used, input logic a_rt_used,
        input logic [4:0] a_ex_rs, input logic [4:0] a_ex_rt, input logic [4:0] a_ex_rd,
        input logic a_mem_read, input logic a_mc,
        input logic [4:0] a_em_rd, input logic a_em_we,
        input logic [4:0] a_mw_rd, input logic a_mw_we);
        in_t v;
        v.id_rs = a_id_rs;   v.id_rt = a_id_rt;
        v.rs_used = a_rs_used; v.rt_used = a_rt_used;
        v.ex_rs = a_ex_rs;   v.ex_rt = a_ex_rt;   v.ex_rd = a_ex_rd;
        v.mem_read = a_mem_read; v.mc = a_mc;
        v.em_rd = a_em_rd;   v.em_we = a_em_we;
        v.mw_rd = a_mw_rd;   v.mw_we = a_mw_we;
        return v;
    endfunction

    function automatic exp_t mk_exp(
        input logic [1:0] fa, input logic [1:0] fb, input logic fir, input logic fit,
        input logic spc, input logic bub, input logic hold, input logic busy, input logic done);
        exp_t e;
        e.fa = fa; e.fb = fb; e.fir = fir; e.fit = fit;
        e.spc = spc; e.bub = bub; e.hold = hold; e.busy = busy; e.done = done;
        return e;
    endfunction

    task automatic apply(input in_t v);
        id_rs = v.id_rs;       id_rt = v.id_rt;
        id_rs_used = v.rs_used; id_rt_used = v.rt_used;
        id_ex_rs = v.ex_rs;    id_ex_rt = v.ex_rt;    id_ex_rd = v.ex_rd;
        id_ex_mem_read = v.mem_read; id_ex_mc = v.mc;
        ex_mem_rd = v.em_rd;   ex_mem_reg_write = v.em_we;
        mem_wb_rd = v.mw_rd;   mem_wb_reg_write = v.mw_we;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare every output of both instances; the stall-count model advances
    // on each cycle where a front-end stall is expected.
    task automatic chk_all(input string tag, input exp_t e);
        int c_main;
        int c_sat;
        c_main = rst ? 0 : exp_cnt;
        c_sat  = (c_main > 3) ? 3 : c_main;
        chk({tag, ".fwd_a"},       32'(fwd_a),       32'(e.fa));
        chk({tag, ".fwd_b"},       32'(fwd_b),       32'(e.fb));
        chk({tag, ".fwd_id_rs"},   32'(fwd_id_rs),   32'(e.fir));
        chk({tag, ".fwd_id_rt"},   32'(fwd_id_rt),   32'(e.fit));
        chk({tag, ".stall_pc"},    32'(stall_pc),    32'(e.spc));
        chk({tag, ".stall_ifid"},  32'(stall_ifid),  32'(e.spc));
        chk({tag, ".bubble_idex"}, 32'(bubble_idex), 32'(e.bub));
        chk({tag, ".hold_ex"},     32'(hold_ex),     32'(e.hold));
        chk({tag, ".mc_busy"},     32'(mc_busy),     32'(e.busy));
        chk({tag, ".mc_done"},     32'(mc_done),     32'(e.done));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(c_main));
        chk({tag, ".sat_count"},   32'(s_stall_count), 32'(c_sat));
        chk({tag, ".sat_outs"},
            32'({s_fwd_a, s_fwd_b, s_fwd_id_rs, s_fwd_id_rt, s_stall_pc, s_bubble_idex,
                 s_hold_ex, s_mc_busy, s_mc_done, s_stall_ifid}),
            32'({e.fa, e.fb, e.fir, e.fit, e.spc, e.bub, e.hold, e.busy, e.done, e.spc}));
        if (!rst && e.spc)
            exp_cnt++;
    endtask

    task automatic step(input in_t v, input string tag, input exp_t e);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
        chk_all(tag, e);
    endtask

    vec_t vecs[13];
    in_t  idle, mc_in, ov_in, lu_in;
    exp_t zero_e, busy_e;

    initial begin
        idle   = '0;
        zero_e = '0;

        vecs[0]  = '{"prio_both",    mk_in(0,0,0,0, 5,0,0,0,0, 5,1,5,1), mk_exp(1,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{"prio_memwb",   mk_in(0,0,0,0, 5,0,0,0,0, 5,0,5,1), mk_exp(2,0,0,0,0,0,0,0,0)};
        vecs[2]  = '{"prio_zero",    mk_in(0,0,0,0, 0,0,0,0,0, 0,1,0,1), mk_exp(0,0,0,0,0,0,0,0,0)};
        vecs[3]  = '{"fwd_b",        mk_in(0,0,0,0, 3,7,0,0,0, 7,1,3,1), mk_exp(2,1,0,0,0,0,0,0,0)};
        vecs[4]  = '{"id_fwd",       mk_in(9,9,1,1, 0,0,0,0,0, 0,0,9,1), mk_exp(0,0,1,1,0,0,0,0,0)};
        vecs[5]  = '{"id_fwd_we0",   mk_in(9,9,1,1, 0,0,0,0,0, 0,0,9,0), mk_exp(0,0,0,0,0,0,0,0,0)};
        vecs[6]  = '{"id_fwd_split", mk_in(9,4,0,0, 0,0,0,0,0, 0,0,4,1), mk_exp(0,0,0,1,0,0,0,0,0)};
        vecs[7]  = '{"lu_rt",        mk_in(0,8,0,1, 0,0,8,1,0, 0,0,0,0), mk_exp(0,0,0,0,1,1,0,0,0)};
        vecs[8]  = '{"lu_bubbled",   mk_in(0,8,0,1, 0,0,8,0,0, 0,0,0,0), mk_exp(0,0,0,0,0,0,0,0,0)};
        vecs[9]  = '{"lu_rt_unused", mk_in(0,8,0,0, 0,0,8,1,0, 0,0,0,0), mk_exp(0,0,0,0,0,0,0,0,0)};
        vecs[10] = '{"lu_rs",        mk_in(8,0,1,0, 0,0,8,1,0, 0,0,0,0), mk_exp(0,0,0,0,1,1,0,0,0)};
        vecs[11] = '{"lu_rd0",       mk_in(0,0,1,1, 0,0,0,1,0, 0,0,0,0), mk_exp(0,0,0,0,0,0,0,0,0)};
        vecs[12] = '{"lu_rt_miss",   mk_in(8,3,0,1, 0,0,8,1,0, 0,0,0,0), mk_exp(0,0,0,0,0,0,0,0,0)};

        // Reset with a forwarding match present: outputs must still read 0.
        rst = 1'b1;
        apply(mk_in(0,0,0,0, 5,0,0,0,0, 5,1,0,0));
        @(negedge clk);
        chk_all("reset", zero_e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(idle);
        @(negedge clk);
        chk_all("post_reset", zero_e);

        for (int i = 0; i < 13; i++)
            step(vecs[i].in, vecs[i].name, vecs[i].ex);

        // Multi-cycle op with live EX/MEM forwarding throughout.
        mc_in  = mk_in(0,0,0,0, 5,0,0,0,1, 5,1,0,0);
        busy_e = mk_exp(1,0,0,0,1,0,1,1,0);
        step(mc_in, "mc_T0", mk_exp(1,0,0,0,1,0,1,0,0));
        step(mc_in, "mc_T1", busy_e);
        step(mc_in, "mc_T2", busy_e);
        step(mc_in, "mc_T3", mk_exp(1,0,0,0,0,0,0,1,1));
        step(mk_in(0,0,0,0, 5,0,0,0,0, 5,1,0,0), "mc_T4", mk_exp(1,0,0,0,0,0,0,0,0));
        step(idle, "mc_T5", zero_e);

        // Multi-cycle entry overlapping a load-use match.
        ov_in = mk_in(0,8,0,1, 0,0,8,1,1, 0,0,0,0);
        step(ov_in, "ov_T0", mk_exp(0,0,0,0,1,0,1,0,0));
        step(ov_in, "ov_T1", mk_exp(0,0,0,0,1,0,1,1,0));
        step(ov_in, "ov_T2", mk_exp(0,0,0,0,1,0,1,1,0));
        step(ov_in, "ov_T3", mk_exp(0,0,0,0,0,0,0,1,1));
        step(idle, "ov_T4", zero_e);

        // Reset in the second cycle of a multi-cycle op.
        step(mc_in, "rst_T0", mk_exp(1,0,0,0,1,0,1,0,0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all("rst_T1", zero_e);
        @(posedge clk);
        exp_cnt = 0;
        #1;
        rst = 1'b0;
        apply(idle);
        @(negedge clk);
        chk_all("rst_T2", zero_e);
        step(idle, "rst_T3", zero_e);
        step(idle, "rst_T4", zero_e);

        // Five consecutive stalls: 16-bit count reaches 5, 2-bit count holds at 3.
        lu_in = mk_in(0,8,0,1, 0,0,8,1,0, 0,0,0,0);
        for (int i = 0; i < 5; i++)
            step(lu_in, "sat_lu", mk_exp(0,0,0,0,1,1,0,0,0));
        step(idle, "sat_end", zero_e);
        chk("sat_final_main", 32'(stall_count), 32'd5);
        chk("sat_final_sat", 32'(s_stall_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
